buzzer_pattern_gen: RTL
=======================

Name: buzzer_pattern_gen

Overview:
Multi-channel, priority-arbitrated buzzer tone and beep-pattern generator; the parametrised successor of the two-tone buzzer driver.
- Each request channel has its own tone half-period and can play either a burst of N beeps or a continuous tone while held.
- Sits between the responder control logic (answer / time-over / fault events) and the buzzer pin.
- Output idles high (buzzer silent).

Parameters:
NUM_CH, 4, number of request channels; index 0 has highest priority
CNT_W, 23, tone counter width
HALF_PER, {4{23'd95419}}, packed NUM_CH*CNT_W vector; channel i half-period in slice [i*CNT_W +: CNT_W]
DUR_W, 24, beep on/off duration counter width
BEEP_ON_CYC, 24'd5000000, cycles per beep ON phase (>=1)
BEEP_OFF_CYC, 24'd5000000, cycles per beep OFF gap (>=1)

Ports:
CLK  input  1  clock
RST  input  1  synchronous active-high reset
Req  input  NUM_CH  per-channel request; burst mode triggers on rising edge, continuous mode uses level
Beep_Num  input  4  beeps per burst, sampled when a request is accepted; 0 selects continuous mode
Buzzer_Out  output  1  tone output, 1 = silent
Busy  output  1  high in ON or OFF state
Active_Ch  output  clog2(NUM_CH) (min 1)  channel currently playing; 0 when idle
Done  output  1  one-cycle pulse when a pattern completes normally (not on preemption)

Behaviour:
- Reset (RST high at a CLK edge): state IDLE, Buzzer_Out=1, Busy=0, Active_Ch=0, Done=0, all counters 0, edge-detect registers take the current Req value. No spurious start when a Req bit is already high as reset releases.
- Edge detect: Req_d registered each cycle; rise[i] = Req[i] & ~Req_d[i].
- Accept: lowest index i with rise[i]=1.
  - Latches ch=i, beeps=Beep_Num.
  - Clears tone and duration counters.
  - Buzzer_Out=1.
  - Enters ON on the next edge; Busy is high from that cycle.
- ON state:
  - Tone counter increments each cycle; when it equals HALF_PER[ch], the counter clears and Buzzer_Out toggles. Full period = 2*(HALF_PER[ch]+1) cycles.
  - Burst mode: duration counter runs 0..BEEP_ON_CYC-1. At terminal count, beeps decrements:
    - result 0 -> IDLE with Done=1 for one cycle;
    - otherwise -> OFF.
  - Continuous mode (beeps=0): stays in ON while Req[ch]=1; Req[ch]=0 -> IDLE with Done pulse. Duration counter is unused.
- OFF state: Buzzer_Out=1; tone counter held at 0; duration counter runs 0..BEEP_OFF_CYC-1, then returns to ON with both counters cleared.
- Preemption: in ON or OFF, rise[j] with j<ch restarts the pattern as a fresh accept of j. No Done pulse. Rises with j>=ch are ignored and not queued.
- Simultaneous rises: lowest index wins; others are dropped.
- Output on leaving ON for any reason: Buzzer_Out is forced to 1 on the same edge.
- Active_Ch updates on the accept edge; it returns to 0 on the edge that enters IDLE.
- Width rule: every HALF_PER slice must be <2^CNT_W. All comparisons are equality on CNT_W / DUR_W bits.

Optional Feature:
BUZZER_MUTE_EN
- Defined: adds input port Mute (1 bit). While Mute=1, Buzzer_Out is forced to 1, but the state machine, counters, Busy, Active_Ch and Done behave exactly as unmuted. Output resumes at the current tone phase when Mute drops.
- Undefined: no Mute port; output follows the state machine only.

Test Plan:
All scenarios use NUM_CH=2, HALF_PER={23'd5,23'd3} (ch0=3, ch1=5), BEEP_ON_CYC=20, BEEP_OFF_CYC=10.
- Reset, then Req=2'b01 held high through RST deassert -> no start; Busy=0 and Buzzer_Out=1 until Req falls and rises again.
- Rise Req[0], Beep_Num=2 -> Busy high for 20+10+20 cycles; Buzzer_Out toggles every 4 cycles in ON phases and is 1 for the 10-cycle gap; Done pulses once; Active_Ch=0.
- Rise Req[1], Beep_Num=0, hold 37 cycles then drop -> toggles every 6 cycles while held; IDLE and Done on the edge after the drop.
- Ch1 burst of 3 playing, rise Req[0] in second ON phase -> no Done; Active_Ch switches to 0 next edge; tone period becomes 8 cycles; ch0 burst completes normally with Done.
- Ch0 playing, rise Req[1] -> ignored, ch0 pattern unchanged; Req[0] and Req[1] rising together from IDLE -> ch0 accepted.
- RST asserted mid ON phase -> next edge IDLE, Buzzer_Out=1, Busy=0, no Done. With BUZZER_MUTE_EN, Mute=1 during a burst -> Buzzer_Out=1 while the Done pulse timing is unchanged.

Source files
------------

// File: rtl/buzzer_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : buzzer_pattern_gen
//  Description : Multi-channel, priority-arbitrated buzzer tone and beep
//                pattern generator. Each channel has its own tone
//                half-period. A channel plays a burst of N beeps, or a
//                continuous tone while its request is held (N = 0).
//                Channel 0 has the highest priority. The output idles high
//                (silent).
//  Options     : BUZZER_MUTE_EN - adds a Mute input that forces the output
//                silent without disturbing the pattern timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module buzzer_pattern_gen #(
    parameter int                      NUM_CH       = 4,
    parameter int                      CNT_W        = 23,
    parameter logic [NUM_CH*CNT_W-1:0] HALF_PER     = {4{23'd95419}},
    parameter int                      DUR_W        = 24,
    parameter logic [DUR_W-1:0]        BEEP_ON_CYC  = 24'd5000000,
    parameter logic [DUR_W-1:0]        BEEP_OFF_CYC = 24'd5000000,
    localparam int                     CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NUM_CH-1:0] Req,
    input  logic [3:0]        Beep_Num,
`ifdef BUZZER_MUTE_EN
    input  logic              Mute,
`endif
    output logic              Buzzer_Out,
    output logic              Busy,
    output logic [CH_W-1:0]   Active_Ch,
    output logic              Done
);

    // Last count of the ON and OFF phases of a beep.
    localparam logic [DUR_W-1:0] c_on_last  = BEEP_ON_CYC  - 1'b1;
    localparam logic [DUR_W-1:0] c_off_last = BEEP_OFF_CYC - 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [CH_W-1:0]    r_ch;
    logic [3:0]         r_beeps;
    logic [CNT_W-1:0]   r_tone_cnt;
    logic [DUR_W-1:0]   r_dur_cnt;
    logic               r_tone;
    logic               r_done;
    logic [NUM_CH-1:0]  r_req_d;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t             w_state_nxt;
    logic [CH_W-1:0]    w_ch_nxt;
    logic [3:0]         w_beeps_nxt;
    logic [CNT_W-1:0]   w_tone_cnt_nxt;
    logic [DUR_W-1:0]   w_dur_cnt_nxt;
    logic               w_tone_nxt;
    logic               w_done_nxt;

    // ------------------------------------------------------------------
    // Arbitration helpers
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0]  w_rise;
    logic               w_any_rise;
    logic [CH_W-1:0]    w_rise_idx;
    logic               w_preempt;
    logic               w_accept;
    logic [CNT_W-1:0]   w_half;
    logic [CNT_W-1:0]   w_half_tab [NUM_CH];

    assign w_rise = Req & ~r_req_d;

    // Unpack the per-channel half-period table.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_half
        assign w_half_tab[g] = HALF_PER[g*CNT_W +: CNT_W];
    end

    assign w_half = w_half_tab[r_ch];

    // Find the lowest-index rising request; scanning downward lets the
    // lowest index overwrite any higher one.
    always_comb begin
        w_any_rise = 1'b0;
        w_rise_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_rise[i]) begin
                w_any_rise = 1'b1;
                w_rise_idx = CH_W'(i);
            end
        end
    end

    // A rise only interrupts a running pattern if it outranks the owner;
    // lower-priority rises are dropped, never queued.
    assign w_preempt = (r_state != S_IDLE) && w_any_rise && (w_rise_idx < r_ch);
    assign w_accept  = ((r_state == S_IDLE) && w_any_rise) || w_preempt;

    // Next-state, counter and output logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_ch_nxt       = r_ch;
        w_beeps_nxt    = r_beeps;
        w_tone_cnt_nxt = r_tone_cnt;
        w_dur_cnt_nxt  = r_dur_cnt;
        w_tone_nxt     = r_tone;
        w_done_nxt     = 1'b0;

        if (w_accept) begin
            // Fresh start (also used for preemption, hence no Done).
            w_state_nxt    = S_ON;
            w_ch_nxt       = w_rise_idx;
            w_beeps_nxt    = Beep_Num;
            w_tone_cnt_nxt = '0;
            w_dur_cnt_nxt  = '0;
            w_tone_nxt     = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_tone_nxt     = 1'b1;
                    w_tone_cnt_nxt = '0;
                    w_dur_cnt_nxt  = '0;
                end

                S_ON: begin
                    // Square wave: toggle each time the half-period elapses.
                    if (r_tone_cnt == w_half) begin
                        w_tone_cnt_nxt = '0;
                        w_tone_nxt     = ~r_tone;
                    end else begin
                        w_tone_cnt_nxt = r_tone_cnt + 1'b1;
                    end

                    if (r_beeps == 4'd0) begin
                        // Continuous tone follows the owning request level.
                        if (!Req[r_ch]) begin
                            w_state_nxt    = S_IDLE;
                            w_done_nxt     = 1'b1;
                            w_ch_nxt       = '0;
                            w_tone_nxt     = 1'b1;
                            w_tone_cnt_nxt = '0;
                            w_dur_cnt_nxt  = '0;
                        end
                    end else if (r_dur_cnt == c_on_last) begin
                        // End of one beep: either the burst is finished or
                        // a silent gap follows.
                        w_beeps_nxt    = r_beeps - 4'd1;
                        w_tone_nxt     = 1'b1;
                        w_tone_cnt_nxt = '0;
                        w_dur_cnt_nxt  = '0;
                        if (r_beeps == 4'd1) begin
                            w_state_nxt = S_IDLE;
                            w_done_nxt  = 1'b1;
                            w_ch_nxt    = '0;
                        end else begin
                            w_state_nxt = S_OFF;
                        end
                    end else begin
                        w_dur_cnt_nxt = r_dur_cnt + 1'b1;
                    end
                end

                S_OFF: begin
                    // Silent gap between beeps; tone phase restarts each beep.
                    w_tone_nxt     = 1'b1;
                    w_tone_cnt_nxt = '0;
                    if (r_dur_cnt == c_off_last) begin
                        w_state_nxt   = S_ON;
                        w_dur_cnt_nxt = '0;
                    end else begin
                        w_dur_cnt_nxt = r_dur_cnt + 1'b1;
                    end
                end

                default: begin
                    w_state_nxt    = S_IDLE;
                    w_ch_nxt       = '0;
                    w_tone_nxt     = 1'b1;
                    w_tone_cnt_nxt = '0;
                    w_dur_cnt_nxt  = '0;
                end
            endcase
        end
    end

    // State register; reset samples Req so a request already high at
    // reset release does not look like a rising edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_ch       <= '0;
            r_beeps    <= '0;
            r_tone_cnt <= '0;
            r_dur_cnt  <= '0;
            r_tone     <= 1'b1;
            r_done     <= 1'b0;
            r_req_d    <= Req;
        end else begin
            r_state    <= w_state_nxt;
            r_ch       <= w_ch_nxt;
            r_beeps    <= w_beeps_nxt;
            r_tone_cnt <= w_tone_cnt_nxt;
            r_dur_cnt  <= w_dur_cnt_nxt;
            r_tone     <= w_tone_nxt;
            r_done     <= w_done_nxt;
            r_req_d    <= Req;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign Busy      = (r_state != S_IDLE);
    assign Active_Ch = r_ch;
    assign Done      = r_done;

`ifdef BUZZER_MUTE_EN
    // Mute only silences the pin; the tone phase keeps running underneath.
    assign Buzzer_Out = r_tone | Mute;
`else
    assign Buzzer_Out = r_tone;
`endif

endmodule
`default_nettype wire
